// File: rtl/game_sequencer.sv
// game_sequencer: owns the 3x3 tic-tac-toe board and alternates player and computer turns.
// It validates each move and latches the outcome reported by the external checker.
// Ports:
//   in : clock, reset (async, active-high), new_game, play/player_position,
//        pc/computer_position, player_win/computer_win/drawn
//   out: pos1..pos9, no_space, player_turn, computer_turn, illegal_move,
//        game_over, winner
// Optional macro AUTO_COMPUTER_EN: the computer plays the lowest empty cell
// itself, and pc/computer_position are ignored.
module game_sequencer #(
  parameter int PLAYER_FIRST = 1,
  parameter int TURN_TIMEOUT = 0,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       play,
  input  logic [3:0] player_position,
  input  logic       pc,
  input  logic [3:0] computer_position,
  input  logic       player_win,
  input  logic       computer_win,
  input  logic       drawn,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       no_space,
  output logic       player_turn,
  output logic       computer_turn,
  output logic       illegal_move,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    PLAYER,
    COMPUTER,
    CHECK,
    OVER
  } state_t;

  localparam state_t FIRST =
    (PLAYER_FIRST != 0) ? PLAYER : COMPUTER;
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TURN_TIMEOUT);

  state_t           state;
  state_t           state_next;
  logic [9:1][1:0]  board;
  logic             next_comp;
  logic             next_comp_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       winner_d;
  logic             illegal_d;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [1:0]       wr_val;
  logic             player_ok;

  // Out-of-range positions read as occupied, so one compare covers both
  // rejection reasons.
  function automatic logic [1:0] cell_at(
    input logic [9:1][1:0] b,
    input logic [3:0]      p
  );
    if (p >= 4'd1 && p <= 4'd9) return b[p];
    return 2'b11;
  endfunction

  assign player_ok = (cell_at(board, player_position) == 2'b00);

  always_comb begin
    no_space = 1'b1;
    for (int i = 1; i <= 9; i++)
      if (board[i] == 2'b00) no_space = 1'b0;
  end

`ifdef AUTO_COMPUTER_EN
  logic [3:0] auto_idx;
  logic       unused_auto;
  assign unused_auto = ^{pc, computer_position};

  always_comb begin
    auto_idx = 4'd0;
    for (int i = 9; i >= 1; i--)
      if (board[i] == 2'b00) auto_idx = 4'(i);
  end
`else
  logic computer_ok;
  assign computer_ok =
    (cell_at(board, computer_position) == 2'b00);
`endif

  always_comb begin
    state_next  = state;
    next_comp_d = next_comp;
    cnt_d       = '0;
    winner_d    = winner;
    illegal_d   = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = 4'd0;
    wr_val      = 2'b00;
    if (new_game) begin
      state_next = FIRST;
      winner_d   = 2'b00;
    end else begin
      unique case (state)
        PLAYER: begin
          if (play && player_ok) begin
            wr_en       = 1'b1;
            wr_idx      = player_position;
            wr_val      = 2'b01;
            next_comp_d = 1'b1;
            state_next  = CHECK;
          end else begin
            illegal_d = play;
            cnt_d     = cnt + 1'b1;
            if (TURN_TIMEOUT != 0 && cnt_d == LIMIT) begin
              state_next = COMPUTER;
              cnt_d      = '0;
            end
          end
        end
        COMPUTER: begin
`ifdef AUTO_COMPUTER_EN
          wr_en       = 1'b1;
          wr_idx      = auto_idx;
          wr_val      = 2'b10;
          next_comp_d = 1'b0;
          state_next  = CHECK;
`else
          if (pc && computer_ok) begin
            wr_en       = 1'b1;
            wr_idx      = computer_position;
            wr_val      = 2'b10;
            next_comp_d = 1'b0;
            state_next  = CHECK;
          end else begin
            illegal_d = pc;
          end
`endif
        end
        CHECK: begin
          if (player_win) begin
            winner_d   = 2'b01;
            state_next = OVER;
          end else if (computer_win) begin
            winner_d   = 2'b10;
            state_next = OVER;
          end else if (drawn || no_space) begin
            winner_d   = 2'b11;
            state_next = OVER;
          end else begin
            state_next = next_comp ? COMPUTER : PLAYER;
          end
        end
        OVER: state_next = OVER;
        default: state_next = FIRST;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= FIRST;
      board        <= '0;
      winner       <= 2'b00;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      cnt          <= '0;
      next_comp    <= 1'b0;
    end else begin
      state        <= state_next;
      winner       <= winner_d;
      illegal_move <= illegal_d;
      cnt          <= cnt_d;
      next_comp    <= next_comp_d;
      // game_over trails entry into OVER by one cycle
      game_over    <= !new_game && (state == OVER);
      if (new_game)   board         <= '0;
      else if (wr_en) board[wr_idx] <= wr_val;
    end
  end

  assign pos1          = board[1];
  assign pos2          = board[2];
  assign pos3          = board[3];
  assign pos4          = board[4];
  assign pos5          = board[5];
  assign pos6          = board[6];
  assign pos7          = board[7];
  assign pos8          = board[8];
  assign pos9          = board[9];
  assign player_turn   = (state == PLAYER);
  assign computer_turn = (state == COMPUTER);

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer.
// The bench models the win/draw checker from the board outputs.
module tb_game_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       play = 1'b0;
  logic       pc = 1'b0;
  logic [3:0] player_position = 4'd0;
  logic [3:0] computer_position = 4'd0;
  logic       player_win;
  logic       computer_win;
  logic       drawn;
  logic [1:0] pos1, pos2, pos3, pos4, pos5;
  logic [1:0] pos6, pos7, pos8, pos9;
  logic       no_space;
  logic       player_turn;
  logic       computer_turn;
  logic       illegal_move;
  logic       game_over;
  logic [1:0] winner;

  game_sequencer #(
    .PLAYER_FIRST(1),
    .TURN_TIMEOUT(8),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .new_game(new_game),
    .play(play),
    .player_position(player_position),
    .pc(pc),
    .computer_position(computer_position),
    .player_win(player_win),
    .computer_win(computer_win),
    .drawn(drawn),
    .pos1(pos1),
    .pos2(pos2),
    .pos3(pos3),
    .pos4(pos4),
    .pos5(pos5),
    .pos6(pos6),
    .pos7(pos7),
    .pos8(pos8),
    .pos9(pos9),
    .no_space(no_space),
    .player_turn(player_turn),
    .computer_turn(computer_turn),
    .illegal_move(illegal_move),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clock = ~clock;

  logic [9:1][1:0] bd;
  assign bd = {pos9, pos8, pos7, pos6, pos5,
               pos4, pos3, pos2, pos1};

  function automatic logic has_line(
    input logic [9:1][1:0] x,
    input logic [1:0]      v
  );
    return (x[1] == v && x[2] == v && x[3] == v) ||
           (x[4] == v && x[5] == v && x[6] == v) ||
           (x[7] == v && x[8] == v && x[9] == v) ||
           (x[1] == v && x[4] == v && x[7] == v) ||
           (x[2] == v && x[5] == v && x[8] == v) ||
           (x[3] == v && x[6] == v && x[9] == v) ||
           (x[1] == v && x[5] == v && x[9] == v) ||
           (x[3] == v && x[5] == v && x[7] == v);
  endfunction

  function automatic logic is_full(input logic [9:1][1:0] x);
    logic f;
    f = 1'b1;
    for (int i = 1; i <= 9; i++)
      if (x[i] == 2'b00) f = 1'b0;
    return f;
  endfunction

  assign player_win   = has_line(bd, 2'b01);
  assign computer_win = has_line(bd, 2'b10);
  assign drawn = is_full(bd) && !player_win && !computer_win;

  typedef struct packed {
    int          cyc;
    logic [17:0] bd;
    logic [6:0]  fl;
  } exp_t;

  exp_t            q[$];
  string           qn[$];
  logic [9:1][1:0] eb = '0;
  int              cyc = 0;
  int              tests = 0;
  int              fails = 0;
  logic            now_tgl = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [6:0] act_fl;
  assign act_fl = {player_turn, computer_turn, illegal_move,
                   game_over, winner, no_space};

  initial forever begin
    @(negedge clock or now_tgl);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = qn.pop_front();
      tests++;
      if (bd !== e.bd || act_fl !== e.fl) begin
        fails++;
        $display("FAIL %s: board=%h flags=%b, expected board=%h flags=%b",
                 n, bd, act_fl, e.bd, e.fl);
      end
    end
  end

  task automatic chk(input string nm, input int d,
                     input logic pt, input logic ct,
                     input logic ill, input logic go,
                     input logic [1:0] w);
    exp_t e;
    logic ns;
    ns = 1'b1;
    for (int i = 1; i <= 9; i++)
      if (eb[i] == 2'b00) ns = 1'b0;
    e.cyc = cyc + d;
    e.bd  = eb;
    e.fl  = {pt, ct, ill, go, w, ns};
    q.push_back(e);
    qn.push_back(nm);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pmove(input logic [3:0] p);
    play = 1'b1;
    player_position = p;
    tick();
    play = 1'b0;
  endtask

  task automatic cmove(input logic [3:0] p);
    pc = 1'b1;
    computer_position = p;
    tick();
    pc = 1'b0;
  endtask

  task automatic ngc(input string nm);
    eb = '0;
    chk(nm, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Accepted move that leaves no line; fin skips the hand-over check.
  task automatic turn(input string nm, input logic comp,
                      input logic [3:0] p, input logic fin);
    eb[p] = comp ? 2'b10 : 2'b01;
    chk({nm, "_chk"}, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    if (comp) cmove(p);
    else pmove(p);
    if (!fin) begin
      chk({nm, "_nxt"}, 1, comp, !comp, 1'b0, 1'b0, 2'b00);
      tick();
    end
  endtask

  initial begin
    chk("reset", 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    reset = 1'b0;

    // player row 1-2-3 wins
    turn("p1", 1'b0, 4'd1, 1'b0);
    turn("c4", 1'b1, 4'd4, 1'b0);
    turn("p2", 1'b0, 4'd2, 1'b0);
    turn("c5", 1'b1, 4'd5, 1'b0);
    turn("p3", 1'b0, 4'd3, 1'b1);
    chk("win_latch", 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    chk("game_over", 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    tick();
    chk("over_play", 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    pmove(4'd6);
    chk("over_pc", 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    cmove(4'd7);

    // wrong-turn strobe, occupied cell, simultaneous strobes
    ngc("ng1");
    turn("p5", 1'b0, 4'd5, 1'b0);
    chk("wrong_turn", 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    pmove(4'd5);
    chk("c_occupied", 1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    cmove(4'd5);
    chk("ill_end", 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    eb[1] = 2'b10;
    chk("both_strobe", 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    play = 1'b1;
    player_position = 4'd2;
    pc = 1'b1;
    computer_position = 4'd1;
    tick();
    play = 1'b0;
    pc = 1'b0;
    chk("back_player", 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();

    // out-of-range positions, pc on player's turn
    ngc("ng2");
    chk("pos0", 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    pmove(4'd0);
    chk("pos12", 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    pmove(4'd12);
    chk("pc_in_player", 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cmove(4'd3);

    // full board, no line
    ngc("ng3");
    turn("d_p1", 1'b0, 4'd1, 1'b0);
    turn("d_c2", 1'b1, 4'd2, 1'b0);
    turn("d_p3", 1'b0, 4'd3, 1'b0);
    turn("d_c5", 1'b1, 4'd5, 1'b0);
    turn("d_p4", 1'b0, 4'd4, 1'b0);
    turn("d_c6", 1'b1, 4'd6, 1'b0);
    turn("d_p8", 1'b0, 4'd8, 1'b0);
    turn("d_c7", 1'b1, 4'd7, 1'b0);
    turn("d_p9", 1'b0, 4'd9, 1'b1);
    chk("draw", 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    chk("draw_over", 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    pmove(4'd1);
    chk("draw_frozen", 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    tick();

    // turn timeout; an illegal move does not restart the count
    ngc("ng4");
    chk("to_ill", 4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("to_7", 7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("to_8", 8, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    repeat (3) tick();
    pmove(4'd0);
    repeat (4) tick();
    turn("to_c7", 1'b1, 4'd7, 1'b0);
    // mid-game new_game drops the simultaneous strobe
    play = 1'b1;
    player_position = 4'd1;
    ngc("ng_mid");
    play = 1'b0;

    // async reset while in CHECK
    eb[2] = 2'b01;
    chk("pre_rst", 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    pmove(4'd2);
    #1 reset = 1'b1;
    #1;
    eb = '0;
    chk("async_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    now_tgl = ~now_tgl;
    #1;
    tick();
    reset = 1'b0;
    turn("post_rst", 1'b0, 4'd5, 1'b0);
    tick();
    tick();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending: %0d checks left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Owns the 3x3 board registers and sequences alternating player and computer moves.
- Validates each move, writes accepted marks into the board and presents the board to the win/draw checker (combinational, external).
- Samples the checker's flags one cycle after every write and latches the final game outcome.
- Sits between the button/switch input logic plus the computer-move source and the display/LED driver.

Parameters:
- PLAYER_FIRST, 1: 1 = player moves first after reset/new_game; 0 = computer first.
- TURN_TIMEOUT, 0: player-turn idle limit in clock cycles; 0 disables; nonzero = turn forfeited to computer when reached.
- CNT_W, 16: width of timeout counter; TURN_TIMEOUT must be < 2^CNT_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  synchronous clear of board, return to first turn.
- play  in  1  player move strobe, one-cycle pulse.
- player_position  in  4  player cell 1..9.
- pc  in  1  computer move strobe, one-cycle pulse.
- computer_position  in  4  computer cell 1..9.
- player_win  in  1  checker flag.
- computer_win  in  1  checker flag.
- drawn  in  1  checker flag.
- pos1..pos9  out  2 each  cell state: 00 empty, 01 player, 10 computer (11 never driven).
- no_space  out  1  all nine cells non-empty.
- player_turn  out  1  high in PLAYER state.
- computer_turn  out  1  high in COMPUTER state.
- illegal_move  out  1  one-cycle pulse on rejected move.
- game_over  out  1  level, high in OVER state.
- winner  out  2  latched outcome: 00 none, 01 player, 10 computer, 11 draw.

Behaviour:
- Reset (async): pos1..pos9 = 00, winner = 00, illegal_move = 0, game_over = 0, timeout counter = 0, state = PLAYER if PLAYER_FIRST else COMPUTER.
- no_space is combinational: AND over all cells of (posN != 00).
- PLAYER state:
  - On play with position in 1..9 and cell empty: write 01, go to CHECK, next_is_computer = 1.
  - On play with position 0, >9, or cell occupied: illegal_move pulses next cycle; stay in PLAYER; board unchanged.
  - pc is ignored.
- COMPUTER state: same rules with pc/computer_position, writing 10; next_is_computer = 0; play is ignored.
- play and pc asserted in the same cycle: only the strobe belonging to the current turn is honoured.
- CHECK (exactly one cycle; checker sees the updated board):
  - player_win → winner = 01, go to OVER.
  - else computer_win → winner = 10, go to OVER.
  - else drawn or no_space → winner = 11, go to OVER.
  - else go to COMPUTER or PLAYER according to next_is_computer.
  - Priority is player > computer > draw.
- OVER: game_over = 1; board and winner frozen; play and pc are ignored; leave only via new_game or reset.
- new_game has priority over every other input in every state:
  - Next cycle: board = 00, winner = 00, counter = 0, state = first-turn state.
  - A strobe in the same cycle is dropped.
- Timeout (TURN_TIMEOUT > 0):
  - Counter clears on entry to PLAYER and increments each PLAYER cycle without an accepted move.
  - On reaching TURN_TIMEOUT: go to COMPUTER with board unchanged.
  - An illegal move does not clear the counter.
- Latency: accepted strobe at edge N → cell visible after N; outcome latched at N+1 (CHECK); game_over high after N+2.

Optional Feature:
- Macro: AUTO_COMPUTER_EN.
- When defined:
  - In COMPUTER state the block ignores pc and computer_position.
  - One cycle after entering COMPUTER it writes 10 into the lowest-numbered empty cell, then goes to CHECK.
  - Because CHECK always catches a full board first, COMPUTER is never entered with the board full.
- When undefined: computer moves come only from pc/computer_position as described above.

Test Plan:
- Reset, PLAYER_FIRST = 1. Player 1, computer 4, player 2, computer 5, player 3 → after player 3, pos1..pos3 = 01; CHECK with player_win = 1 gives winner = 01, and game_over is high two cycles after the play strobe.
- Player 5, then player strobe at 5 again on the computer's turn, then computer at 5 → second player strobe has no effect; computer 5 is rejected with illegal_move one-cycle pulse; state stays COMPUTER; pos5 = 01.
- Player position 0, then position 12 → two illegal_move pulses; board all 00; player_turn stays 1.
- Nine-move full board with no line (player 1,3,4,8,9; computer 2,5,6,7) and checker drawn = 1 → winner = 11; no_space = 1; later play strobes are ignored.
- TURN_TIMEOUT = 8, no play for 8 cycles → computer_turn = 1, board unchanged; then new_game mid-game → board cleared, winner = 00, player_turn = 1 next cycle.
- Assert reset asynchronously mid-CHECK → all outputs return to reset values immediately, without waiting for a clock edge.
